// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: controller state encoding
// and the default character width.
package uart_pkg;

    localparam int UART_DBIT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2
    } tx_ctrl_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with a separate occupancy counter, a
// combinational head output and a registered overflow pulse.
module sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              wr_ok_s, rd_ok_s;

    assign full     = (count_q == (ADDR_W + 1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign rd_data  = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a write into a full FIFO is
    // still accepted when it coincides with a pop.
    assign rd_ok_s = rd_en && !empty;
    assign wr_ok_s = wr_en && (!full || rd_ok_s);

    // Next-state for pointers, occupancy and the drop pulse.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = wr_en && !wr_ok_s;
        if (wr_ok_s) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_ok_s) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Transmit buffer plus launch controller: pops one byte at a time into din,
// pulses tx_en for one cycle and waits for tx_done_tick before the next.
module uart_tx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DBIT   = UART_DBIT,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [DBIT-1:0]  wr_data,
    output logic             full,
    output logic             empty,
    output logic [ADDR_W:0]  count,
    output logic             overflow,
    output logic             tx_busy,
    output logic             tx_en,
    output logic [DBIT-1:0]  din,
    input  logic             tx_done_tick
);

    tx_ctrl_state_t  state_q, state_d;
    logic            tx_en_q, tx_en_d;
    logic [DBIT-1:0] din_q, din_d;
    logic            pop_s;
    logic [DBIT-1:0] head_s;
    logic            empty_s;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DBIT)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop_s),
        .rd_data  (head_s),
        .count    (count),
        .full     (full),
        .empty    (empty_s),
        .overflow (overflow)
    );

    assign empty   = empty_s;
    assign tx_en   = tx_en_q;
    assign din     = din_q;
    assign tx_busy = (state_q != IDLE);

    // Launch sequencing; tx_done_tick outside BUSY is treated as spurious.
    always_comb begin
        state_d = state_q;
        tx_en_d = 1'b0;
        din_d   = din_q;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    din_d   = head_s;
                    tx_en_d = 1'b1;
                    state_d = LAUNCH;
                end else begin
                    state_d = IDLE;
                end
            end
            LAUNCH: begin
                state_d = BUSY;
            end
            BUSY: begin
                if (tx_done_tick) begin
                    state_d = IDLE;
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and transmitter-facing output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tx_en_q <= 1'b0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            tx_en_q <= tx_en_d;
            din_q   <= din_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Self-checking bench: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx_fifo_ctrl;

    localparam int DEPTH = 4;
    localparam int DBIT  = 8;
    localparam int AW    = $clog2(DEPTH);

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            wr_en = 1'b0;
    logic [DBIT-1:0] wr_data = '0;
    logic            tx_done_tick = 1'b0;
    logic            full, empty, overflow, tx_busy, tx_en;
    logic [AW:0]     count;
    logic [DBIT-1:0] din;

    int n_vec  = 0;
    int n_fail = 0;
    int tx_cnt = 0;

    // Reference model: byte queue plus a coarse "where is the controller" stage
    // (0 waiting for data, 1 pulse just issued, 2 frame in flight).
    logic [DBIT-1:0] m_q[$];
    int              m_stage = 0;
    bit              m_tx_en = 1'b0;
    bit              m_ovf   = 1'b0;
    logic [DBIT-1:0] m_din   = '0;

    uart_tx_fifo_ctrl #(.DEPTH(DEPTH), .DBIT(DBIT)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .tx_busy      (tx_busy),
        .tx_en        (tx_en),
        .din          (din),
        .tx_done_tick (tx_done_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model update at every active edge (inputs are stable there).
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_q.delete();
                m_stage = 0;
                m_tx_en = 1'b0;
                m_ovf   = 1'b0;
                m_din   = '0;
            end else begin
                bit pop, acc;
                pop = (m_stage == 0) && (m_q.size() != 0);
                acc = wr_en && ((m_q.size() < DEPTH) || pop);
                m_ovf   = wr_en && !acc;
                m_tx_en = pop;
                if (pop) begin
                    m_din   = m_q.pop_front();
                    m_stage = 1;
                end else if (m_stage == 1) begin
                    m_stage = 2;
                end else if (m_stage == 2 && tx_done_tick) begin
                    m_stage = 0;
                end
                if (acc) m_q.push_back(wr_data);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("m_count",    32'(count),    32'(m_q.size()));
            check("m_full",     32'(full),     32'(m_q.size() == DEPTH));
            check("m_empty",    32'(empty),    32'(m_q.size() == 0));
            check("m_overflow", 32'(overflow), 32'(m_ovf));
            check("m_tx_en",    32'(tx_en),    32'(m_tx_en));
            check("m_tx_busy",  32'(tx_busy),  32'(m_stage != 0));
            check("m_din",      32'(din),      32'(m_din));
        end
    end

    task automatic drive(input bit w, input logic [DBIT-1:0] d, input bit t);
        wr_en        = w;
        wr_data      = d;
        tx_done_tick = t;
        @(negedge clk);
    endtask

    // Random host writes with a transmitter that finishes 2..8 cycles after
    // each launch, plus occasional spurious done pulses while it is quiet.
    task automatic run_random(input int cycles, input int wr_pct);
        for (int i = 0; i < cycles; i++) begin
            bit d;
            d = 1'b0;
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) d = 1'b1;
            end else if ($urandom_range(0, 39) == 0) begin
                d = 1'b1;
            end
            drive(($urandom_range(0, 99) < wr_pct), 8'($urandom), d);
            if (tx_en) tx_cnt = $urandom_range(2, 8);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((m_q.size() != 0 || m_stage != 0) && k < 500) begin
            run_random(1, 0);
            k++;
        end
        check("drain_done", 32'(m_q.size() == 0 && m_stage == 0), 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) drive(1'b0, 8'h00, 1'b0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full",  32'(full),  32'd0);
        check("rst_tx_en", 32'(tx_en), 32'd0);
        check("rst_din",   32'(din),   32'd0);
        check("rst_busy",  32'(tx_busy), 32'd0);
        #2 reset = 1'b0;
        drive(1'b0, 8'h00, 1'b0);

        // Spurious done while idle and empty
        drive(1'b0, 8'h00, 1'b1);
        check("spur_busy",  32'(tx_busy), 32'd0);
        check("spur_tx_en", 32'(tx_en),   32'd0);
        drive(1'b0, 8'h00, 1'b0);
        check("spur_tx_en2", 32'(tx_en), 32'd0);

        // Single byte: tx_en two cycles after the write edge
        drive(1'b1, 8'hA5, 1'b0);
        check("sb_count1", 32'(count), 32'd1);
        check("sb_tx_en0", 32'(tx_en), 32'd0);
        drive(1'b0, 8'h00, 1'b0);
        check("sb_tx_en1", 32'(tx_en), 32'd1);
        check("sb_din",    32'(din),   32'hA5);
        check("sb_count0", 32'(count), 32'd0);
        drive(1'b0, 8'h00, 1'b0);
        check("sb_pulse_width", 32'(tx_en), 32'd0);
        check("sb_busy", 32'(tx_busy), 32'd1);
        drive(1'b0, 8'h00, 1'b0);
        check("sb_busy2", 32'(tx_busy), 32'd1);
        drive(1'b0, 8'h00, 1'b1);
        check("sb_idle",    32'(tx_busy), 32'd0);
        check("sb_din_hold", 32'(din), 32'hA5);

        // Full / overflow: six writes, first is launched, four stored, last dropped
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'(8'h30 + i), 1'b0);
            if (i == 4) begin
                check("ov_full5", 32'(full), 32'd1);
                check("ov_no_ovf5", 32'(overflow), 32'd0);
            end
        end
        check("ov_overflow", 32'(overflow), 32'd1);
        check("ov_count",    32'(count),    32'd4);
        check("ov_first_din", 32'(din),     32'h30);
        drive(1'b0, 8'h00, 1'b0);
        check("ov_pulse_width", 32'(overflow), 32'd0);
        drive(1'b0, 8'h00, 1'b1);
        check("wf_idle", 32'(tx_busy), 32'd0);
        // Write while full coinciding with a pop
        drive(1'b1, 8'h77, 1'b0);
        check("wf_tx_en",  32'(tx_en),    32'd1);
        check("wf_din",    32'(din),      32'h31);
        check("wf_count",  32'(count),    32'd4);
        check("wf_no_ovf", 32'(overflow), 32'd0);
        check("wf_full",   32'(full),     32'd1);
        tx_cnt = 3;
        drain();

        // Randomized traffic at two write densities
        run_random(1500, 30);
        run_random(1500, 70);
        drain();

        // Reset mid-frame with three bytes queued
        for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), 1'b0);
        check("mr_count3", 32'(count),   32'd3);
        check("mr_busy",   32'(tx_busy), 32'd1);
        #2 reset = 1'b1;
        tx_cnt = 0;
        drive(1'b0, 8'h00, 1'b0);
        check("mr_tx_en", 32'(tx_en),   32'd0);
        check("mr_din",   32'(din),     32'd0);
        check("mr_count", 32'(count),   32'd0);
        check("mr_empty", 32'(empty),   32'd1);
        check("mr_busy0", 32'(tx_busy), 32'd0);
        #2 reset = 1'b0;
        drive(1'b1, 8'h5A, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        check("mr_relaunch",     32'(tx_en), 32'd1);
        check("mr_relaunch_din", 32'(din),   32'h5A);
        tx_cnt = 3;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_ctrl.md
Name: uart_tx_fifo_ctrl

Overview:
- Transmit-side buffer and launch controller that sits directly upstream of the UART transmitter.
- Accepts bytes from a host write port into a DEPTH-entry synchronous FIFO.
- Issues one byte at a time to the transmitter through a single-cycle tx_en pulse with registered din.
- Holds off the next launch until the transmitter reports tx_done_tick, so frames go out back-to-back with no data loss.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of 2 and at least 2.
- DBIT, 8, data width; must match the transmitter's DBIT.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- wr_en  input  1  host write strobe; one byte per cycle.
- wr_data  input  DBIT  host byte, sampled when wr_en=1.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse when a write is dropped.
- tx_busy  output  1  high while state is not IDLE.
- tx_en  output  1  registered launch pulse to the transmitter, one cycle wide.
- din  output  DBIT  registered byte to the transmitter; valid while tx_en=1 and held afterwards.
- tx_done_tick  input  1  transmitter end-of-frame pulse.

Behaviour:
- Reset values:
  - state=IDLE, tx_en=0, din=0, overflow=0.
  - count=0, so empty=1 and full=0; tx_busy=0.
  - Read and write pointers = 0.
  - Reset mid-frame discards all FIFO contents and any pending launch. The transmitter shares this reset, so both sides restart in IDLE.
- FIFO:
  - Circular buffer with ADDR_W-bit pointers that wrap modulo DEPTH.
  - count is a separate register.
  - full and empty decode combinationally from the registered count.
- Pop:
  - Internal signal, asserted only by the controller in IDLE when empty=0.
  - The head byte is registered into din on the same edge that pops it.
- Write acceptance:
  - A write is accepted iff wr_en=1 and (full=0 or pop=1 in the same cycle).
  - Otherwise the write is dropped, overflow pulses for 1 cycle, and storage and count are unchanged.
- Count update:
  - Write and pop in the same cycle: count unchanged, both pointers advance.
  - Write only: count+1.
  - Pop only: count-1.
- No bypass path. A byte written into an empty FIFO becomes visible to the controller on the next cycle.
- Controller FSM (shared state enum):
  - IDLE:
    - If empty=0: pop, din<=head, tx_en<=1, next state LAUNCH.
    - Else: tx_en<=0.
  - LAUNCH:
    - tx_en<=0; the pulse is exactly 1 cycle.
    - Next state BUSY.
  - BUSY:
    - Wait for tx_done_tick=1, then go to IDLE.
    - din holds its value.
  - tx_done_tick in IDLE or LAUNCH is ignored; it is a spurious pulse.
- Latency:
  - Write into empty FIFO at edge N: pop decided in cycle N+1, tx_en high in cycle N+2.
  - tx_done_tick at cycle M: FSM is IDLE at M+1, next tx_en at M+2. The transmitter is already IDLE at M+1, so the pulse is never missed.
- Throughput: one frame per transmitter frame time plus 2 clk of gap.

Decomposition:
- Shared package uart_pkg:
  - typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} tx_ctrl_state_t.
  - Constant UART_DBIT = 8.
- One sub-module, sync_fifo:
  - Parameters DEPTH and WIDTH.
  - Ports: wr_en, wr_data, rd_en, rd_data (head, combinational), count, full, empty, and an overflow pulse.
- uart_tx_fifo_ctrl instantiates sync_fifo and contains the FSM and the output registers.

Test Plan:
- Single byte: write 0xA5 into an empty FIFO -> tx_en high for exactly 1 cycle, 2 cycles after the write; din=0xA5; count returns to 0; tx_busy stays high until 1 cycle after tx_done_tick.
- Burst: write 0x11, 0x22, 0x33 on consecutive cycles, with a transmitter model (or real uart_tx, SB_TICK=16) in the loop -> three tx_en pulses in order 0x11, 0x22, 0x33; each subsequent pulse 2 cycles after the prior tx_done_tick; serial line decodes the same bytes.
- Full/overflow (DEPTH=4, tx_done_tick tied low after the first launch): write 6 bytes -> first byte launched; 4 stored so full=1; 6th write dropped with one overflow pulse; count=4.
- Write while full during a pop: hold full, pulse tx_done_tick so the controller pops in the same cycle as wr_en -> write accepted, no overflow, count stays 4, pointers wrap correctly past DEPTH-1.
- Reset mid-operation: assert reset while in BUSY with count=3 -> next cycle tx_en=0, din=0, count=0, empty=1, state IDLE; a later write of 0x5A launches normally.
- Spurious done: pulse tx_done_tick while IDLE and empty -> no state change, no tx_en.
